door_game_ctrl: RTL and testbench

Round controller for the door-guessing game. It sits directly upstream of the screen drawer and supplies its `correct_door` and `time_up` inputs, plus lives, score and countdown values for on-screen display. It picks a pseudo-random door each round, runs a per-second countdown, and latches the player's single choice. At expiry it reveals the correct door and updates lives and score, ending the game when lives reach zero.

---
 rtl/game_pkg.sv | 27 ++
 rtl/door_game_ctrl_tick_gen.sv | 35 +++
 rtl/door_game_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_door_game_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the door-guessing game.
//   game_state_t : round controller states
//   door_t       : door index 0..3
//   LFSR_SEED    : LFSR value after reset
//   LFSR_TAPS    : feedback mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   lfsr_next()  : one Fibonacci LFSR step
package game_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ROUND     = 2'd1,
        REVEAL    = 2'd2,
        GAME_OVER = 2'd3
    } game_state_t;

    typedef logic [1:0] door_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Shift left and feed the XOR of the tapped bits into bit 0.
    // A nonzero state never maps to zero.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/door_game_ctrl_tick_gen.sv
// One-second prescaler.
//   clk   : system clock
//   reset : synchronous, active-low
//   clear : holds the count at zero (used on state entry)
//   tick  : high during the last cycle of each TICK_DIV-cycle period
module tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_r;

    // Prescaler count: wraps after LAST, forced to zero by reset or clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r <= ZERO;
        end else if (clear || (cnt_r == LAST)) begin
            cnt_r <= ZERO;
        end else begin
            cnt_r <= cnt_r + ONE;
        end
    end

    assign tick = (cnt_r == LAST);

endmodule

// File: rtl/door_game_ctrl.sv
// Round controller for the door-guessing game.
//   clk, reset     : clock, synchronous active-low reset
//   start          : begins a game from IDLE or GAME_OVER
//   choice_valid   : one-cycle door-button pulse, qualifies choice
//   choice         : chosen door 0..3
//   correct_door   : door drawn for the current round
//   time_up        : high while the correct door is revealed
//   seconds_left   : round countdown for display
//   lives, score   : remaining lives, rounds won (saturating)
//   game_over      : high in GAME_OVER
module door_game_ctrl
    import game_pkg::*;
#(
    parameter int TICK_DIV       = 25_000_000,
    parameter int ROUND_SECONDS  = 10,
    parameter int REVEAL_SECONDS = 3,
    parameter int LIVES          = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       choice_valid,
    input  logic [1:0] choice,
    output logic [1:0] correct_door,
    output logic       time_up,
    output logic [3:0] seconds_left,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic       game_over
);

    localparam logic [3:0] ROUND_SECS  = 4'(ROUND_SECONDS);
    localparam logic [3:0] REVEAL_SECS = 4'(REVEAL_SECONDS);
    localparam logic [1:0] LIVES_INIT  = 2'(LIVES);

    game_state_t state_r;
    logic [7:0]  lfsr_r;
    door_t       correct_door_r;
    logic        time_up_r;
    logic [3:0]  secs_r;
    logic [3:0]  reveal_cnt_r;
    logic [1:0]  lives_r;
    logic [7:0]  score_r;
    logic        game_over_r;
    logic        latch_full_r;
    door_t       latch_door_r;

    logic        tick_s;
    logic        clear_s;
    logic        pick_valid_s;
    door_t       pick_door_s;
    logic        win_s;

    // Every exit from ROUND and REVEAL happens on a tick, where the
    // prescaler wraps by itself; holding it clear in the waiting states
    // makes ROUND entry start on a fresh second as well.
    always_comb begin
        clear_s = 1'b0;
        if ((state_r == IDLE) || (state_r == GAME_OVER)) begin
            clear_s = 1'b1;
        end else begin
            clear_s = 1'b0;
        end
    end

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .clear(clear_s),
        .tick (tick_s)
    );

    // Effective pick: the latched choice, or a pulse arriving on this
    // very cycle when the latch is still empty (final-tick pick).
    always_comb begin
        pick_valid_s = 1'b0;
        pick_door_s  = 2'd0;
        if (latch_full_r) begin
            pick_valid_s = 1'b1;
            pick_door_s  = latch_door_r;
        end else if (choice_valid) begin
            pick_valid_s = 1'b1;
            pick_door_s  = choice;
        end else begin
            pick_valid_s = 1'b0;
            pick_door_s  = 2'd0;
        end
        win_s = pick_valid_s && (pick_door_s == correct_door_r);
    end

    // Game FSM with LFSR, choice latch, countdowns, lives and score.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r        <= IDLE;
            lfsr_r         <= LFSR_SEED;
            correct_door_r <= 2'd0;
            time_up_r      <= 1'b0;
            secs_r         <= 4'd0;
            reveal_cnt_r   <= 4'd0;
            lives_r        <= LIVES_INIT;
            score_r        <= 8'd0;
            game_over_r    <= 1'b0;
            latch_full_r   <= 1'b0;
            latch_door_r   <= 2'd0;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r        <= ROUND;
                        correct_door_r <= lfsr_r[1:0];
                        secs_r         <= ROUND_SECS;
                        latch_full_r   <= 1'b0;
                        time_up_r      <= 1'b0;
                    end
                end
                ROUND: begin
                    if (choice_valid && !latch_full_r) begin
                        latch_full_r <= 1'b1;
                        latch_door_r <= choice;
                    end
                    if (tick_s) begin
                        if (secs_r == 4'd1) begin
                            state_r      <= REVEAL;
                            secs_r       <= 4'd0;
                            time_up_r    <= 1'b1;
                            reveal_cnt_r <= REVEAL_SECS;
                            if (win_s) begin
                                if (score_r != 8'hFF) begin
                                    score_r <= score_r + 8'd1;
                                end
                            end else begin
                                // lives >= 1 here: REVEAL never returns to ROUND at 0
                                lives_r <= lives_r - 2'd1;
                            end
                        end else begin
                            secs_r <= secs_r - 4'd1;
                        end
                    end
                end
                REVEAL: begin
                    if (tick_s) begin
                        if (reveal_cnt_r == 4'd1) begin
                            time_up_r <= 1'b0;
                            if (lives_r == 2'd0) begin
                                state_r     <= GAME_OVER;
                                game_over_r <= 1'b1;
                            end else begin
                                state_r        <= ROUND;
                                correct_door_r <= lfsr_r[1:0];
                                secs_r         <= ROUND_SECS;
                                latch_full_r   <= 1'b0;
                            end
                        end else begin
                            reveal_cnt_r <= reveal_cnt_r - 4'd1;
                        end
                    end
                end
                GAME_OVER: begin
                    if (start) begin
                        state_r        <= ROUND;
                        lives_r        <= LIVES_INIT;
                        score_r        <= 8'd0;
                        game_over_r    <= 1'b0;
                        correct_door_r <= lfsr_r[1:0];
                        secs_r         <= ROUND_SECS;
                        latch_full_r   <= 1'b0;
                        time_up_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign correct_door = correct_door_r;
    assign time_up      = time_up_r;
    assign seconds_left = secs_r;
    assign lives        = lives_r;
    assign score        = score_r;
    assign game_over    = game_over_r;

endmodule

// File: tb/tb_door_game_ctrl.sv
// Randomized scoreboard bench for door_game_ctrl.
module tb_door_game_ctrl;

    localparam int TD = 4;
    localparam int RS = 3;
    localparam int VS = 2;
    localparam int LV = 3;
    localparam int ROUND_CYC = RS * TD;
    localparam int REV_CYC   = VS * TD;
    localparam int RND_CYC   = ROUND_CYC + REV_CYC;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       choice_valid = 1'b0;
    logic [1:0] choice = 2'd0;
    logic [1:0] correct_door;
    logic       time_up;
    logic [3:0] seconds_left;
    logic [1:0] lives;
    logic [7:0] score;
    logic       game_over;

    door_game_ctrl #(
        .TICK_DIV(TD), .ROUND_SECONDS(RS), .REVEAL_SECONDS(VS), .LIVES(LV)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .choice_valid(choice_valid), .choice(choice),
        .correct_door(correct_door), .time_up(time_up),
        .seconds_left(seconds_left), .lives(lives),
        .score(score), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        int door;
        int lives;
        int score;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   ecnt = 0;          // clock edges seen with reset released
    logic [7:0] seq [0:254]; // LFSR value after k released edges
    int   m_e;               // edge number at which the current round began
    int   m_lives;
    int   m_score;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        if (!reset) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    // Monitor: reveal entry pops the scoreboard; also times ROUND length,
    // REVEAL length and the countdown steps.
    int   run = 0;
    int   tu_len = 0;
    logic prev_tu = 1'b0;
    int   prev_secs = 0;
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            exp_q.delete();
            run = 0; tu_len = 0; prev_tu = 1'b0; prev_secs = 0;
        end else begin
            if (time_up && !prev_tu) begin
                if (exp_q.size() == 0) begin
                    chk("reveal_unexpected", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("reveal_door",  int'(correct_door), mon_e.door);
                    chk("reveal_lives", int'(lives), mon_e.lives);
                    chk("reveal_score", int'(score), mon_e.score);
                    chk("reveal_secs",  int'(seconds_left), 0);
                    chk("round_len",    run, ROUND_CYC);
                end
            end
            if (!time_up && prev_tu) chk("reveal_len", tu_len, REV_CYC);
            if (seconds_left != 4'd0 && prev_secs != 0 && int'(seconds_left) != prev_secs) begin
                chk("secs_step", int'(seconds_left), prev_secs - 1);
                chk("secs_spacing", run % TD, 0);
            end
            run       = (seconds_left != 4'd0) ? run + 1 : 0;
            tu_len    = time_up ? tu_len + 1 : 0;
            prev_tu   = time_up;
            prev_secs = int'(seconds_left);
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_door"},  int'(correct_door), 0);
        chk({tag, "_tu"},    int'(time_up), 0);
        chk({tag, "_secs"},  int'(seconds_left), 0);
        chk({tag, "_lives"}, int'(lives), LV);
        chk({tag, "_score"}, int'(score), 0);
        chk({tag, "_go"},    int'(game_over), 0);
    endtask

    // Called at a negedge; start is sampled on the next edge.
    task automatic start_game();
        m_e = ecnt + 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_lives = LV;
        m_score = 0;
        chk("entry_lives", int'(lives), LV);
        chk("entry_score", int'(score), 0);
        chk("entry_go", int'(game_over), 0);
    endtask

    // Modes: 0 none, 1 correct, 2 wrong, 3 wrong then correct,
    // 4 correct then wrong, 5 correct on final tick, 6 wrong on final tick.
    // Called at the negedge just after the round-entry edge.
    task automatic play_round(input int mode, input int abort_j);
        int door, wrong, first, second, j1, j2, rj, rc;
        door  = int'(seq[(m_e - 1) % 255] & 8'h03);
        wrong = (door + int'($urandom_range(1, 3))) % 4;
        chk("entry_door", int'(correct_door), door);
        chk("entry_secs", int'(seconds_left), RS);
        chk("entry_tu", int'(time_up), 0);
        j1 = int'($urandom_range(1, ROUND_CYC - 1));
        j2 = int'($urandom_range(j1 + 1, ROUND_CYC));
        if (mode >= 5) j1 = ROUND_CYC;
        first  = (mode == 1 || mode == 4 || mode == 5) ? door : wrong;
        second = (mode == 3) ? door : wrong;
        if (mode != 0 && first == door) m_score = (m_score < 255) ? m_score + 1 : 255;
        else                            m_lives = m_lives - 1;
        exp_q.push_back('{door: door, lives: m_lives, score: m_score});
        rj = int'($urandom_range(ROUND_CYC + 1, RND_CYC));
        rc = int'($urandom_range(0, 3));
        for (int j = 1; j <= RND_CYC; j++) begin
            choice_valid = 1'b0;
            choice = 2'($urandom_range(0, 3));
            start = ($urandom_range(0, 3) == 0);
            if (mode != 0 && j == j1) begin choice_valid = 1'b1; choice = 2'(first); end
            if ((mode == 3 || mode == 4) && j == j2) begin choice_valid = 1'b1; choice = 2'(second); end
            if (j == rj) begin choice_valid = 1'b1; choice = 2'(rc); end
            if (j == abort_j) begin
                choice_valid = 1'b0; start = 1'b0; reset = 1'b0;
                @(negedge clk);
                chk_reset_vals("midrst");
                reset = 1'b1;
                repeat (6) @(negedge clk);
                chk_reset_vals("postrst");
                return;
            end
            @(negedge clk);
        end
        choice_valid = 1'b0;
        start = 1'b0;
    endtask

    // policy 0: directed openers then random; policy 1: long winning run
    task automatic play_game(input int policy);
        int mode;
        start_game();
        for (int r = 0; r < 400; r++) begin
            if (policy == 1)  mode = (r < 257) ? 1 : 2;
            else if (r == 0)  mode = 1;
            else if (r == 1)  mode = 0;
            else if (r == 2)  mode = 3;
            else if (r == 3)  mode = 5;
            else              mode = int'($urandom_range(0, 6));
            play_round(mode, 0);
            if (m_lives == 0) begin
                chk("go_flag",  int'(game_over), 1);
                chk("go_lives", int'(lives), 0);
                chk("go_tu",    int'(time_up), 0);
                repeat (3) @(negedge clk);
                chk("go_door_hold", int'(correct_door), int'(seq[(m_e - 1) % 255] & 8'h03));
                chk("go_score", int'(score), m_score);
                return;
            end
            m_e += RND_CYC;
        end
        chk("game_bound", m_lives, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        seq[0] = 8'hA5;
        for (int i = 1; i < 255; i++)
            seq[i] = {seq[i-1][6:0], seq[i-1][7] ^ seq[i-1][5] ^ seq[i-1][4] ^ seq[i-1][3]};
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk_reset_vals("idle");
        play_game(0);
        repeat ($urandom_range(1, 5)) @(negedge clk);
        play_game(0);
        repeat ($urandom_range(1, 5)) @(negedge clk);
        play_game(1);
        repeat (2) @(negedge clk);
        start_game();
        play_round(1, ROUND_CYC + 3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
